// File: rtl/serial_subtractor_nb_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Handshake: Start is sampled only while idle; Busy marks the WIDTH shift cycles and Done pulses once when Diff/Bout/Ovf update.
interface serial_subtractor_nb_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    logic [1:0]       state_dbg;

    modport master (
        output Start, A, B, Bin,
        input  Busy, Done, Diff, Bout, Ovf, state_dbg
    );

    modport slave (
        input  Start, A, B, Bin,
        output Busy, Done, Diff, Bout, Ovf, state_dbg
    );
endinterface

// File: rtl/serial_subtractor_nb.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flop
// computes A - B - Bin over WIDTH cycles; results are held until the next Done.
module serial_subtractor_nb #(
    parameter int WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    serial_subtractor_nb_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             r;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    logic             d;
    logic             r_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ r;
        r_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & r);
        res_next = {d, res[WIDTH-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            r     <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.Start) begin
                        a_sr  <= bus.A;
                        b_sr  <= bus.B;
                        r     <= bus.Bin;
                        res   <= '0;
                        cnt   <= '0;
                        a_msb <= bus.A[WIDTH-1];
                        b_msb <= bus.B[WIDTH-1];
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res  <= res_next;
                    r    <= r_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + 1'b1;
                    // The final bit is folded straight into the held outputs on this edge.
                    if (cnt == LAST) begin
                        diff  <= res_next;
                        bout  <= r_next;
                        ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Diff      = diff;
    assign bus.Bout      = bout;
    assign bus.Ovf       = ovf;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Self-checking bench for serial_subtractor_nb (WIDTH=4): directed scenarios plus
// randomized operations scored against an arithmetic reference model.
module tb_serial_subtractor_nb;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   done_cnt;
    logic [W+1:0] exp_q[$];

    serial_subtractor_nb_if #(.WIDTH(W)) bus ();

    serial_subtractor_nb #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: plain integer subtraction and the MSB-based overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int full;
        logic [W-1:0] dv;
        logic bo, ov;
        full = int'(a) - int'(b) - int'(bin);
        dv   = W'(full);
        bo   = (full < 0);
        ov   = (a[W-1] != b[W-1]) && (dv[W-1] != a[W-1]);
        return {dv, bo, ov};
    endfunction

    // Scoreboard: every Done pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.Done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("diff", bus.Diff, e[W+1:2]);
                check("bout", bus.Bout, e[1]);
                check("ovf",  bus.Ovf,  e[0]);
            end
        end
    end

    // Driver: issue one op from idle and check the Busy/Done timing; operands are
    // scrambled while busy to show they are not re-sampled.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        exp_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_high", bus.Busy, 1);
            check("done_low_busy", bus.Done, 0);
            bus.A   = W'($urandom_range(0, (1 << W) - 1));
            bus.B   = W'($urandom_range(0, (1 << W) - 1));
            bus.Bin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("done_pulse", bus.Done, 1);
        check("busy_at_done", bus.Busy, 0);
        @(negedge clk);
        check("done_one_cycle", bus.Done, 0);
    endtask

    initial begin
        int start_cnt;
        int last_done;
        int seen;
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        done_cnt = 0;
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_diff", bus.Diff, 0);
        check("rst_bout", bus.Bout, 0);
        check("rst_ovf",  bus.Ovf, 0);
        check("rst_state", bus.state_dbg, 0);

        // Directed scenarios 1-3
        run_op(4'd9, 4'd3, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        run_op(4'd0, 4'd0, 1'b1);
        run_op(4'd8, 4'd1, 1'b0);

        // Scenario 4: Start re-asserted while busy must be ignored
        start_cnt = done_cnt;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.A = 4'd5;
        bus.B = 4'd2;
        bus.Bin = 1'b0;
        exp_q.push_back(model(4'd5, 4'd2, 1'b0));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.Start = 1'b1;
            bus.A = 4'd1;
            bus.B = 4'd1;
        end
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignored_start_one_done", done_cnt - start_cnt, 1);

        // Scenario 6: reset mid-operation aborts it (results made non-zero first)
        run_op(4'd3, 4'd9, 1'b1);
        start_cnt = done_cnt;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.A = 4'd9;
        bus.B = 4'd3;
        bus.Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        check("abort_diff", bus.Diff, 0);
        check("abort_bout", bus.Bout, 0);
        check("abort_ovf",  bus.Ovf, 0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - start_cnt, 0);
        run_op(4'd12, 4'd4, 1'b0);

        // Scenario 5: Start held high gives one op every W+2 cycles
        @(negedge clk);
        bus.Start = 1'b1;
        bus.A = 4'd7;
        bus.B = 4'd7;
        bus.Bin = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(4'd7, 4'd7, 1'b0));
        seen = 0;
        last_done = 0;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                if (seen > 0) check("held_start_period", cyc - last_done, W + 2);
                last_done = cyc;
                seen++;
            end
        end
        bus.Start = 1'b0;
        check("held_start_done_count", seen, 3);
        repeat (3) @(negedge clk);

        // Randomized operations with random idle gaps
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                   1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
